// File: rtl/compare_scoreboard.sv
// compare_scoreboard: counts samples and mismatches between a golden output
// (out_ref) and a design output (out_dut) over a run of num_samples samples.
//
// Handshake: there is no ready. While busy is high, every cycle with valid=1
// is consumed and checked on that rising edge. With valid=0 nothing happens.
// Outside RUN, valid is ignored. start is a one-cycle request. It is honoured
// only in IDLE or DONE. abort is honoured only in RUN.
//
// state_dbg mirrors the FSM state register (0=IDLE, 1=RUN, 2=DONE).
module compare_scoreboard #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             abort,
    input  logic             valid,
    input  logic [WIDTH-1:0] out_ref,
    input  logic [WIDTH-1:0] out_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] errors,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld,
    output logic [WIDTH-1:0] err_mask,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] target, target_nx;
    logic [CNT_W-1:0] samples_nx, errors_nx, first_err_idx_nx;
    logic             first_err_vld_nx;
    logic [WIDTH-1:0] err_mask_nx;

    logic [WIDTH-1:0] diff;
    logic             mismatch;
    logic [CNT_W-1:0] samples_inc;

    assign diff        = out_ref ^ out_dut;
    assign mismatch    = |diff;
    assign samples_inc = samples + CNT_W'(1);
    assign state_dbg   = state;

    // State register; reset discards any run in progress.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and next values of all counters and result fields.
    always_comb begin
        state_nx         = state;
        target_nx        = target;
        samples_nx       = samples;
        errors_nx        = errors;
        first_err_idx_nx = first_err_idx;
        first_err_vld_nx = first_err_vld;
        err_mask_nx      = err_mask;
        case (state)
            RUN: begin
                if (valid) begin
                    samples_nx = samples_inc;
                    if (mismatch) begin
                        errors_nx   = errors + CNT_W'(1);
                        err_mask_nx = err_mask | diff;
                        // The index is the pre-increment count, i.e. 0-based.
                        if (!first_err_vld) begin
                            first_err_idx_nx = samples;
                            first_err_vld_nx = 1'b1;
                        end
                    end
                end
                // The closing sample (or an aborting one) is still counted above.
                if ((valid && (samples_inc == target)) || abort) begin
                    state_nx = DONE;
                end
            end
            // IDLE, DONE and the unused encoding all wait for start.
            default: begin
                if (start) begin
                    samples_nx       = '0;
                    errors_nx        = '0;
                    first_err_idx_nx = '0;
                    first_err_vld_nx = 1'b0;
                    err_mask_nx      = '0;
                    target_nx        = num_samples;
                    state_nx         = (num_samples == '0) ? DONE : RUN;
                end
            end
        endcase
    end

    // Result and status registers. Status flags come from the next state, so
    // they line up with the state register.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            target        <= '0;
            samples       <= '0;
            errors        <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            err_mask      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            target        <= target_nx;
            samples       <= samples_nx;
            errors        <= errors_nx;
            first_err_idx <= first_err_idx_nx;
            first_err_vld <= first_err_vld_nx;
            err_mask      <= err_mask_nx;
            busy          <= (state_nx == RUN);
            done          <= (state_nx == DONE);
            pass          <= (state_nx == DONE) && (errors_nx == '0);
        end
    end

endmodule

// File: tb/tb_compare_scoreboard.sv
// Testbench for compare_scoreboard. A behavioural model tracks each run as
// stimulus is driven. It pushes the expected result word when the run should
// end. Each test pops that word and compares it once done is observed.
module tb_compare_scoreboard;

    localparam int WIDTH = 2;
    localparam int CNT_W = 16;
    // Result word: {pass, first_err_vld, err_mask, first_err_idx, errors, samples}
    localparam int RES_W = 3 * CNT_W + WIDTH + 2;

    logic             clk = 1'b0;
    logic             areset_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;
    logic             abort = 1'b0;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] out_ref = '0;
    logic [WIDTH-1:0] out_dut = '0;
    logic             busy, done, pass, first_err_vld;
    logic [CNT_W-1:0] samples, errors, first_err_idx;
    logic [WIDTH-1:0] err_mask;
    logic [1:0]       state_dbg;

    compare_scoreboard #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .areset_n(areset_n), .start(start), .num_samples(num_samples),
        .abort(abort), .valid(valid), .out_ref(out_ref), .out_dut(out_dut),
        .busy(busy), .done(done), .pass(pass), .samples(samples), .errors(errors),
        .first_err_idx(first_err_idx), .first_err_vld(first_err_vld),
        .err_mask(err_mask), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [RES_W-1:0] exp_q[$];
    logic [RES_W-1:0] exp_v, obs_v, last_v;

    bit               m_run = 1'b0;
    logic [CNT_W-1:0] m_target = '0, m_samples = '0, m_errors = '0, m_fidx = '0;
    logic             m_fvld = 1'b0;
    logic [WIDTH-1:0] m_mask = '0;

    function automatic logic [RES_W-1:0] observed();
        return {pass, first_err_vld, err_mask, first_err_idx, errors, samples};
    endfunction

    task automatic push_expect();
        exp_q.push_back({(m_errors == '0), m_fvld, m_mask, m_fidx, m_errors, m_samples});
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [CNT_W-1:0] n, input logic ab);
        if (!m_run) begin
            m_samples = '0; m_errors = '0; m_fidx = '0; m_fvld = 1'b0; m_mask = '0;
            m_target  = n;
            m_run     = (n != '0);
            if (n == '0) push_expect();
        end
        start = 1'b1; num_samples = n; abort = ab;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; num_samples = CNT_W'($urandom_range(0, 50));
    endtask

    task automatic send(input logic v, input logic [WIDTH-1:0] r,
                        input logic [WIDTH-1:0] d, input logic ab);
        if (m_run && v) begin
            if (r !== d) begin
                m_errors = m_errors + 1'b1;
                m_mask   = m_mask | (r ^ d);
                if (!m_fvld) begin m_fidx = m_samples; m_fvld = 1'b1; end
            end
            m_samples = m_samples + 1'b1;
        end
        if (m_run && ((v && m_samples == m_target) || ab)) begin
            m_run = 1'b0;
            push_expect();
        end
        valid = v; out_ref = r; out_dut = d; abort = ab;
        @(posedge clk); #1;
        valid = 1'b0; abort = 1'b0;
        out_ref = WIDTH'($urandom_range(0, 3)); out_dut = WIDTH'($urandom_range(0, 3));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total_cnt++;
        if ({busy, done, state_dbg} !== 4'b0 || observed() !== '0)
            $display("FAIL reset_state: got busy=%b done=%b st=%0d res=%h want all 0",
                     busy, done, state_dbg, observed());
        else pass_cnt++;
        areset_n = 1'b1;
        send(1'b1, 2'b01, 2'b10, 1'b0);
        total_cnt++;
        if (state_dbg !== 2'd0 || samples !== '0)
            $display("FAIL idle_ignores_valid: got st=%0d samples=%0d want 0/0", state_dbg, samples);
        else pass_cnt++;
    endtask

    task automatic test_all_match();
        logic [WIDTH-1:0] b;
        do_start(16'd4, 1'b0);
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || state_dbg !== 2'd1)
            $display("FAIL match_busy: got busy=%b done=%b pass=%b st=%0d want 1/0/0/1",
                     busy, done, pass, state_dbg);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (done !== 1'b0)
                $display("FAIL match_early_done: got done=%b before sample %0d want 0", done, i);
            else pass_cnt++;
            b = WIDTH'($urandom_range(0, 1));
            send(1'b1, b, b, 1'b0);
        end
        total_cnt++;
        if (exp_q.size() == 0 || done !== 1'b1) begin
            $display("FAIL match_result: got done=%b queued=%0d want done=1", done, exp_q.size());
        end else begin
            exp_v = exp_q.pop_front(); obs_v = observed();
            if (obs_v !== exp_v) $display("FAIL match_result: got %h want %h", obs_v, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_mismatch();
        do_start(16'd5, 1'b0);
        send(1'b1, 2'b11, 2'b11, 1'b0);
        send(1'b1, 2'b10, 2'b10, 1'b0);
        send(1'b1, 2'b01, 2'b00, 1'b0);
        send(1'b1, 2'b00, 2'b00, 1'b0);
        send(1'b1, 2'b10, 2'b00, 1'b0);
        total_cnt++;
        if (exp_q.size() == 0 || done !== 1'b1) begin
            $display("FAIL mismatch_result: got done=%b queued=%0d want done=1", done, exp_q.size());
        end else begin
            exp_v = exp_q.pop_front(); obs_v = observed();
            if (obs_v !== exp_v) $display("FAIL mismatch_result: got %h want %h", obs_v, exp_v);
            else pass_cnt++;
        end
        total_cnt++;
        if (errors !== 16'd2 || first_err_idx !== 16'd2 || first_err_vld !== 1'b1
            || err_mask !== 2'b11 || pass !== 1'b0)
            $display("FAIL mismatch_fields: got err=%0d idx=%0d vld=%b mask=%b pass=%b want 2/2/1/11/0",
                     errors, first_err_idx, first_err_vld, err_mask, pass);
        else pass_cnt++;
    endtask

    task automatic test_gaps();
        do_start(16'd6, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 2'b01, 2'b10, 1'b0);
            total_cnt++;
            if (samples !== m_samples || done !== 1'b0)
                $display("FAIL gap_hold: got samples=%0d done=%b want %0d/0", samples, done, m_samples);
            else pass_cnt++;
            send(1'b1, 2'b11, 2'b11, 1'b0);
        end
        total_cnt++;
        if (exp_q.size() == 0 || done !== 1'b1) begin
            $display("FAIL gap_result: got done=%b queued=%0d want done=1", done, exp_q.size());
        end else begin
            exp_v = exp_q.pop_front(); obs_v = observed();
            if (obs_v !== exp_v) $display("FAIL gap_result: got %h want %h", obs_v, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        do_start(16'd10, 1'b0);
        send(1'b1, 2'b00, 2'b00, 1'b0);
        send(1'b1, 2'b11, 2'b11, 1'b0);
        send(1'b1, 2'b01, 2'b11, 1'b1);
        total_cnt++;
        if (exp_q.size() == 0 || done !== 1'b1) begin
            $display("FAIL abort_result: got done=%b queued=%0d want done=1", done, exp_q.size());
        end else begin
            exp_v = exp_q.pop_front(); obs_v = observed();
            if (obs_v !== exp_v) $display("FAIL abort_result: got %h want %h", obs_v, exp_v);
            else pass_cnt++;
        end
        total_cnt++;
        if (samples !== 16'd3 || errors !== 16'd1 || first_err_idx !== 16'd2 || busy !== 1'b0)
            $display("FAIL abort_fields: got samples=%0d err=%0d idx=%0d busy=%b want 3/1/2/0",
                     samples, errors, first_err_idx, busy);
        else pass_cnt++;
    endtask

    task automatic test_zero_then_two();
        do_start(16'd0, 1'b0);
        total_cnt++;
        if (exp_q.size() == 0 || done !== 1'b1 || pass !== 1'b1 || state_dbg !== 2'd2) begin
            $display("FAIL zero_run: got done=%b pass=%b st=%0d queued=%0d want 1/1/2",
                     done, pass, state_dbg, exp_q.size());
        end else begin
            exp_v = exp_q.pop_front(); obs_v = observed();
            if (obs_v !== exp_v) $display("FAIL zero_run: got %h want %h", obs_v, exp_v);
            else pass_cnt++;
        end
        do_start(16'd2, 1'b0);
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0 || samples !== '0 || errors !== '0)
            $display("FAIL restart_clear: got busy=%b done=%b samples=%0d err=%0d want 1/0/0/0",
                     busy, done, samples, errors);
        else pass_cnt++;
        send(1'b1, 2'b10, 2'b10, 1'b0);
        send(1'b1, 2'b01, 2'b01, 1'b0);
        total_cnt++;
        if (exp_q.size() == 0 || done !== 1'b1) begin
            $display("FAIL two_run: got done=%b queued=%0d want done=1", done, exp_q.size());
        end else begin
            exp_v = exp_q.pop_front(); obs_v = observed();
            if (obs_v !== exp_v) $display("FAIL two_run: got %h want %h", obs_v, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        do_start(16'd3, 1'b0);
        send(1'b1, 2'b00, 2'b00, 1'b0);
        do_start(16'd7, 1'b0);                    // ignored while running
        send(1'b1, 2'b00, 2'b01, 1'b0);
        send(1'b1, 2'b11, 2'b11, 1'b0);
        total_cnt++;
        if (exp_q.size() == 0 || done !== 1'b1) begin
            $display("FAIL start_in_run: got done=%b samples=%0d queued=%0d want done at 3",
                     done, samples, exp_q.size());
        end else begin
            exp_v = exp_q.pop_front(); obs_v = observed();
            if (obs_v !== exp_v) $display("FAIL start_in_run: got %h want %h", obs_v, exp_v);
            else pass_cnt++;
        end
        last_v = exp_v;
        for (int i = 0; i < 3; i++) send(1'b1, 2'b10, 2'b01, 1'b1);
        total_cnt++;
        if (observed() !== last_v || done !== 1'b1)
            $display("FAIL done_hold: got %h done=%b want %h done=1", observed(), done, last_v);
        else pass_cnt++;
        do_start(16'd2, 1'b1);                    // start+abort from DONE acts as start
        total_cnt++;
        if (busy !== 1'b1 || samples !== '0 || first_err_vld !== 1'b0)
            $display("FAIL start_abort: got busy=%b samples=%0d vld=%b want 1/0/0",
                     busy, samples, first_err_vld);
        else pass_cnt++;
        send(1'b1, 2'b01, 2'b01, 1'b0);
        send(1'b1, 2'b11, 2'b10, 1'b0);
        total_cnt++;
        if (exp_q.size() == 0 || done !== 1'b1) begin
            $display("FAIL start_abort_run: got done=%b queued=%0d want done=1", done, exp_q.size());
        end else begin
            exp_v = exp_q.pop_front(); obs_v = observed();
            if (obs_v !== exp_v) $display("FAIL start_abort_run: got %h want %h", obs_v, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(16'd8, 1'b0);
        send(1'b1, 2'b01, 2'b00, 1'b0);
        send(1'b1, 2'b10, 2'b10, 1'b0);
        send(1'b1, 2'b11, 2'b00, 1'b0);
        #2 areset_n = 1'b0;                       // between edges: must act at once
        m_run = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, state_dbg} !== 4'b0 || observed() !== '0)
            $display("FAIL async_reset: got busy=%b done=%b st=%0d res=%h want all 0",
                     busy, done, state_dbg, observed());
        else pass_cnt++;
        #1 areset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(1'b1, 2'b01, 2'b10, 1'b0);
        total_cnt++;
        if (samples !== '0 || errors !== '0 || busy !== 1'b0 || state_dbg !== 2'd0)
            $display("FAIL post_reset_idle: got samples=%0d err=%0d busy=%b st=%0d want 0/0/0/0",
                     samples, errors, busy, state_dbg);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] r, d;
        int cyc;
        for (int run = 0; run < 6; run++) begin
            do_start(CNT_W'($urandom_range(1, 12)), 1'b0);
            cyc = 0;
            while (m_run && cyc < 200) begin
                r = WIDTH'($urandom_range(0, 3));
                d = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom_range(0, 3)) : r;
                send($urandom_range(0, 3) != 0, r, d, $urandom_range(0, 15) == 0);
                cyc++;
            end
            total_cnt++;
            if (exp_q.size() == 0 || done !== 1'b1) begin
                $display("FAIL random_run%0d: got done=%b queued=%0d want done=1",
                         run, done, exp_q.size());
            end else begin
                exp_v = exp_q.pop_front(); obs_v = observed();
                if (obs_v !== exp_v) $display("FAIL random_run%0d: got %h want %h", run, obs_v, exp_v);
                else pass_cnt++;
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_all_match();
        test_mismatch();
        test_gaps();
        test_abort();
        test_zero_then_two();
        test_hold();
        test_reset_mid_run();
        test_random();
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/compare_scoreboard.md
COMPARE_SCOREBOARD -- requirements
Module: compare_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning bit width of the compared output vectors.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the sample, error and index counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port areset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a comparison run.
REQ-006 SHALL have port num_samples  input  CNT_W  run length in valid samples, latched on accepted start.
REQ-007 SHALL have port abort  input  1  terminates an active run early.
REQ-008 SHALL have port valid  input  1  out_ref/out_dut hold a sample this cycle.
REQ-009 SHALL have port out_ref  input  WIDTH  golden model output.
REQ-010 SHALL have port out_dut  input  WIDTH  design-under-test output.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  high while in DONE.
REQ-013 SHALL have port pass  output  1  high in DONE when errors == 0.
REQ-014 SHALL have port samples  output  CNT_W  valid samples consumed this run.
REQ-015 SHALL have port errors  output  CNT_W  mismatching samples this run.
REQ-016 SHALL have port first_err_idx  output  CNT_W  0-based sample index of first mismatch.
REQ-017 SHALL have port first_err_vld  output  1  first_err_idx is meaningful.
REQ-018 SHALL have port err_mask  output  WIDTH  OR-accumulated out_ref ^ out_dut over mismatching samples.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-020 In IDLE or DONE, start=1 SHALL clear samples, errors, first_err_idx, first_err_vld, err_mask, latch num_samples, enter RUN next cycle.
REQ-021 start with num_samples == 0 SHALL go directly to DONE next cycle with counters cleared and pass=1.
REQ-022 start while in RUN SHALL be ignored.
REQ-023 In RUN, valid=1 SHALL increment samples by 1; valid=0 SHALL change no counter.
REQ-024 A sample SHALL be a mismatch when out_ref != out_dut on any bit; a mismatch SHALL increment errors and OR out_ref ^ out_dut into err_mask.
REQ-025 On the first mismatch of a run, first_err_idx SHALL capture the pre-increment samples value and first_err_vld SHALL set; later mismatches SHALL not alter either.
REQ-026 The valid sample that brings samples to the latched num_samples SHALL be counted, and the FSM SHALL enter DONE on the next edge (done high one cycle after last sample).
REQ-027 valid samples in IDLE or DONE SHALL be ignored.
REQ-028 abort=1 in RUN SHALL enter DONE next cycle with partial counts; a valid sample in the same cycle SHALL still be counted and checked.
REQ-029 abort in IDLE or DONE SHALL be ignored; start and abort together in IDLE/DONE SHALL act as start.
REQ-030 DONE SHALL hold all results stable until the next start or reset.
REQ-031 pass SHALL be 0 outside DONE; in DONE pass = (errors == 0).

Reset
REQ-032 areset_n low SHALL immediately force IDLE, busy=0, done=0, pass=0, samples=0, errors=0, first_err_idx=0, first_err_vld=0, err_mask=0, regardless of clk.
REQ-033 Reset asserted mid-RUN SHALL discard the run; after release the block SHALL wait in IDLE for start.

Verification
REQ-034 WIDTH=1, start num_samples=4, 4 valid samples with out_ref==out_dut -> done high the cycle after 4th sample, samples=4, errors=0, pass=1, first_err_vld=0.
REQ-035 WIDTH=2, num_samples=5, mismatches at indices 2 (ref=01,dut=00) and 4 (ref=10,dut=00) -> errors=2, first_err_idx=2, first_err_vld=1, err_mask=11, pass=0.
REQ-036 num_samples=6 with valid deasserted on alternate cycles -> samples increments only on valid cycles, done after 6th valid sample.
REQ-037 num_samples=10, abort asserted together with 3rd valid sample (mismatching) -> DONE next cycle, samples=3, errors=1, first_err_idx=2.
REQ-038 start num_samples=0 -> DONE next cycle, pass=1, samples=0; then start num_samples=2 from DONE -> counters cleared, new run completes with samples=2.
REQ-039 areset_n pulsed low mid-run after 3 samples -> all outputs 0 immediately; subsequent valid samples ignored until start.
